image_mem_scheduler: RTL and testbench

- Shares one single-port synchronous image RAM (2^(IMG_W_LOG2+IMG_H_LOG2) x 8) between two users: the VGA display fetch, which is real-time, and a host write port with a req/ack handshake.
- Computes the RAM address from the VGA pixel coordinates and a movable image origin.
- Delivers a pipelined pixel value; the screen area outside the image shows a background colour.
- Sits between the VGA sync generator and the image RAM, so a cartoon image can be repositioned and redrawn while it is displayed.

---
 rtl/image_mem_scheduler.sv | 149 ++++++++++++++
 tb/tb_image_mem_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_mem_scheduler.sv
// Arbitrates a single-port image RAM between the real-time VGA display fetch and a
// host req/ack write port, and maps screen coordinates onto a movable image window.
module image_mem_scheduler #(
    parameter int          IMG_W_LOG2 = 8,
    parameter int          IMG_H_LOG2 = 8,
    parameter int          V_ACTIVE   = 480,
    parameter logic [7:0]  BG_COLOR   = 8'h00,
    localparam int         AW         = IMG_W_LOG2 + IMG_H_LOG2
) (
    input  logic          clk_25,
    input  logic          rst_n,
    input  logic [9:0]    s_pixel_row,
    input  logic [9:0]    s_pixel_col,
    input  logic          video_on,
    input  logic [9:0]    org_x,
    input  logic [9:0]    org_y,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    pix_data,
    output logic          pix_valid
);

    localparam logic [10:0] IMG_W = 11'(2 ** IMG_W_LOG2);
    localparam logic [10:0] IMG_H = 11'(2 ** IMG_H_LOG2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      ox_q, ox_d, oy_q, oy_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;
    logic            wr_ack_q, wr_ack_d;
    logic            v1_q, v1_d, v2_q, v2_d;
    logic [7:0]      pix_data_q, pix_data_d;
    logic            pix_valid_q, pix_valid_d;

    logic            in_win;
    logic            origin_latch;
    logic [9:0]      row_off, col_off;
    logic [AW-1:0]   disp_addr;
    logic [10:0]     col_x, row_x, ox_x, oy_x;

    // One bit of headroom so a window reaching past column/line 1023 clips instead of wrapping.
    assign col_x  = {1'b0, s_pixel_col};
    assign row_x  = {1'b0, s_pixel_row};
    assign ox_x   = {1'b0, ox_q};
    assign oy_x   = {1'b0, oy_q};
    assign in_win = video_on && (col_x >= ox_x) && (col_x < ox_x + IMG_W)
                             && (row_x >= oy_x) && (row_x < oy_x + IMG_H);

    assign row_off   = s_pixel_row - oy_q;
    assign col_off   = s_pixel_col - ox_q;
    assign disp_addr = {row_off[IMG_H_LOG2-1:0], col_off[IMG_W_LOG2-1:0]};

    assign origin_latch = (s_pixel_row == 10'(V_ACTIVE)) && (s_pixel_col == 10'd0);

    always_comb begin
        state_d     = state_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 1'b0;

        if (origin_latch) begin
            ox_d = org_x;
            oy_d = org_y;
        end

        if (in_win) begin
            mem_addr_d = disp_addr;
        end

        // Writes only steal slots the display does not need.
        case (state_q)
            ST_IDLE: begin
                if (wr_req && !in_win) begin
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_data;
                    mem_we_d    = 1'b1;
                    state_d     = ST_WR;
                end
            end
            ST_WR: begin
                wr_ack_d = 1'b1;
                state_d  = ST_ACK;
            end
            ST_ACK: begin
                if (!wr_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        v1_d        = in_win && !mem_we_d;
        v2_d        = v1_q;
        pix_data_d  = v2_q ? mem_rdata : BG_COLOR;
        pix_valid_d = v2_q;
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ox_q        <= '0;
            oy_q        <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ack_q    <= wr_ack_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_image_mem_scheduler.sv
// Bench for image_mem_scheduler: drives pixel coordinates and host writes, attaches a
// behavioural RAM, and checks every pixel and write against an image-level model.
module tb_image_mem_scheduler;

    localparam int         AW = 16;
    localparam logic [7:0] BG = 8'h00;
    localparam int         IW = 256;
    localparam int         IH = 256;

    logic          clk_25 = 1'b0;
    logic          rst_n = 1'b1;
    logic [9:0]    s_pixel_row = '0;
    logic [9:0]    s_pixel_col = '0;
    logic          video_on = 1'b0;
    logic [9:0]    org_x = '0;
    logic [9:0]    org_y = '0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [7:0]    pix_data;
    logic          pix_valid;

    image_mem_scheduler dut (
        .clk_25(clk_25), .rst_n(rst_n),
        .s_pixel_row(s_pixel_row), .s_pixel_col(s_pixel_col), .video_on(video_on),
        .org_x(org_x), .org_y(org_y),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid)
    );

    always #20 clk_25 = ~clk_25;

    // Single-port synchronous RAM, read-first.
    logic [7:0] ram [0:65535];
    always @(posedge clk_25) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model: image contents, current origin, and a 2-deep expected-pixel pipe.
    logic [7:0] img [0:65535];
    int         mox, moy;
    logic [7:0] pipe_pix [2];
    logic       pipe_v [2];
    logic [7:0] exp_pix;
    logic       exp_valid;
    int         we_cnt = 0, ack_cnt = 0, viol = 0;
    int         n_cmp = 0, n_fail = 0;

    function automatic bit m_win(int r, int c, bit v, int ox, int oy);
        return v && (c >= ox) && (c < ox + IW) && (r >= oy) && (r < oy + IH);
    endfunction

    function automatic int m_addr(int r, int c, int ox, int oy);
        return (((r - oy) & (IH - 1)) * IW) + ((c - ox) & (IW - 1));
    endfunction

    task automatic model_reset();
        mox = 0; moy = 0;
        for (int i = 0; i < 2; i++) begin pipe_pix[i] = BG; pipe_v[i] = 1'b0; end
        exp_pix = BG; exp_valid = 1'b0;
    endtask

    // Advance one clock; afterwards exp_pix/exp_valid describe what pix_data should show now.
    task automatic tick();
        bit win;
        int a;
        win = m_win(int'(s_pixel_row), int'(s_pixel_col), video_on, mox, moy);
        a   = m_addr(int'(s_pixel_row), int'(s_pixel_col), mox, moy);
        @(posedge clk_25);
        if (s_pixel_row == 10'd480 && s_pixel_col == 10'd0) begin
            mox = int'(org_x); moy = int'(org_y);
        end
        #1;
        if (mem_we === 1'b1) begin we_cnt++; if (win) viol++; end
        if (wr_ack === 1'b1) begin ack_cnt++; img[wr_addr] = wr_data; end
        exp_pix = pipe_pix[1]; exp_valid = pipe_v[1];
        pipe_pix[1] = pipe_pix[0]; pipe_v[1] = pipe_v[0];
        pipe_pix[0] = win ? img[a] : BG;
        pipe_v[0]   = win;
    endtask

    task automatic set_px(int r, int c, bit v);
        s_pixel_row = 10'(r); s_pixel_col = 10'(c); video_on = v;
    endtask

    task automatic test_reset();
        int ack0;
        #5 rst_n = 1'b0;
        #1;
        n_cmp++; if ({mem_addr, mem_we, mem_wdata, wr_ack, pix_data, pix_valid} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got addr=%h we=%b wdata=%h ack=%b pix=%h/%b expected all zero",
                               mem_addr, mem_we, mem_wdata, wr_ack, pix_data, pix_valid); end
        @(posedge clk_25); @(posedge clk_25); @(negedge clk_25);
        rst_n = 1'b1;
        model_reset();
        set_px(10, 300, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (pix_data !== BG || pix_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_bg: got %h/%b expected %h/0", pix_data, pix_valid, BG); end
        end
        // Reset arriving while a write is on the RAM port.
        wr_addr = 16'h0042; wr_data = img[16'h0042]; wr_req = 1'b1;
        tick();
        n_cmp++; if (mem_we !== 1'b1) begin
            n_fail++; $display("FAIL reset_prewrite_we: got %b expected 1", mem_we); end
        #5 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_midwrite_we: got %b expected 0", mem_we); end
        n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_midwrite_bus: got addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata); end
        n_cmp++; if (wr_ack !== 1'b0 || pix_data !== '0 || pix_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_midwrite_out: got ack=%b pix=%h/%b expected 0", wr_ack, pix_data, pix_valid); end
        wr_req = 1'b0;
        @(posedge clk_25); @(negedge clk_25);
        rst_n = 1'b1;
        model_reset();
        ack0 = ack_cnt;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++; if (ack_cnt !== ack0) begin
            n_fail++; $display("FAIL reset_no_ack: got %0d acks expected 0", ack_cnt - ack0); end
    endtask

    task automatic test_default_origin();
        set_px(3, 5, 1'b1);
        tick();
        n_cmp++; if (mem_addr !== 16'h0305) begin
            n_fail++; $display("FAIL def_addr: got %h expected 0305", mem_addr); end
        set_px(3, 256, 1'b1); tick();
        set_px(3, 300, 1'b1); tick();
        n_cmp++; if (pix_data !== 8'h06 || pix_valid !== 1'b1) begin
            n_fail++; $display("FAIL def_pix: got %h/%b expected 06/1", pix_data, pix_valid); end
        tick();
        n_cmp++; if (pix_data !== BG || pix_valid !== 1'b0) begin
            n_fail++; $display("FAIL def_col256: got %h/%b expected %h/0", pix_data, pix_valid, BG); end
        for (int i = 0; i < 300; i++) begin
            set_px($urandom_range(0, 299), $urandom_range(0, 399), ($urandom % 8) != 0);
            tick();
            n_cmp++; if (pix_data !== exp_pix || pix_valid !== exp_valid) begin
                n_fail++; $display("FAIL def_rand: got %h/%b expected %h/%b", pix_data, pix_valid, exp_pix, exp_valid); end
        end
    endtask

    task automatic test_origin_move();
        org_x = 10'd100; org_y = 10'd50;
        set_px(200, 10, 1'b1); tick();
        set_px(50, 100, 1'b1); tick();
        n_cmp++; if (mem_addr !== 16'h3264) begin
            n_fail++; $display("FAIL org_premove_addr: got %h expected 3264", mem_addr); end
        set_px(480, 0, 1'b0); tick();
        set_px(50, 100, 1'b1); tick();
        n_cmp++; if (mem_addr !== 16'h0000) begin
            n_fail++; $display("FAIL org_moved_addr: got %h expected 0000", mem_addr); end
        set_px(49, 100, 1'b1); tick();
        set_px(60, 5, 1'b1); tick();
        n_cmp++; if (pix_data !== 8'h00 || pix_valid !== 1'b1) begin
            n_fail++; $display("FAIL org_moved_pix: got %h/%b expected 00/1", pix_data, pix_valid); end
        tick();
        n_cmp++; if (pix_data !== BG || pix_valid !== 1'b0) begin
            n_fail++; $display("FAIL org_above_bg: got %h/%b expected %h/0", pix_data, pix_valid, BG); end
        for (int f = 0; f < 16; f++) begin
            org_x = 10'($urandom_range(0, 1023)); org_y = 10'($urandom_range(0, 1023));
            set_px(480, 0, 1'b0); tick();
            for (int i = 0; i < 120; i++) begin
                set_px(moy + $urandom_range(0, 300) - 20, mox + $urandom_range(0, 300) - 20, 1'b1);
                tick();
                n_cmp++; if (pix_data !== exp_pix || pix_valid !== exp_valid) begin
                    n_fail++; $display("FAIL org_rand: got %h/%b expected %h/%b org=%0d,%0d",
                                       pix_data, pix_valid, exp_pix, exp_valid, mox, moy); end
            end
        end
        org_x = '0; org_y = '0;
        set_px(480, 0, 1'b0); tick();
    endtask

    task automatic test_write_outside();
        set_px(10, 300, 1'b1);
        wr_addr = 16'h1234; wr_data = 8'hA5; wr_req = 1'b1;
        tick();
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 16'h1234 || mem_wdata !== 8'hA5 || wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL wr_issue: got we=%b addr=%h data=%h ack=%b expected 1/1234/a5/0",
                               mem_we, mem_addr, mem_wdata, wr_ack); end
        wr_req = 1'b0;
        tick();
        n_cmp++; if (mem_we !== 1'b0 || wr_ack !== 1'b1) begin
            n_fail++; $display("FAIL wr_ack: got we=%b ack=%b expected 0/1", mem_we, wr_ack); end
        tick();
        n_cmp++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse: got %b expected 0", wr_ack); end
        set_px(480, 0, 1'b0); tick();
        set_px(18, 52, 1'b1); tick();
        set_px(18, 300, 1'b1); tick();
        tick();
        n_cmp++; if (pix_data !== 8'hA5 || pix_valid !== 1'b1) begin
            n_fail++; $display("FAIL wr_readback: got %h/%b expected a5/1", pix_data, pix_valid); end
    endtask

    task automatic test_deferred();
        int we0, ack0;
        wr_addr = 16'h8001; wr_data = 8'h5A; wr_req = 1'b1;
        for (int c = 10; c < 256; c++) begin
            set_px(20, c, 1'b1);
            tick();
            n_cmp++; if (mem_we !== 1'b0 || pix_data !== exp_pix || pix_valid !== exp_valid) begin
                n_fail++; $display("FAIL defer_col%0d: got we=%b pix=%h/%b expected we=0 pix=%h/%b",
                                   c, mem_we, pix_data, pix_valid, exp_pix, exp_valid); end
        end
        set_px(20, 256, 1'b1); tick();
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 16'h8001) begin
            n_fail++; $display("FAIL defer_issue: got we=%b addr=%h expected 1/8001", mem_we, mem_addr); end
        set_px(20, 257, 1'b1); tick();
        n_cmp++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL defer_ack: got %b expected 1", wr_ack); end
        wr_req = 1'b0;
        for (int c = 258; c < 262; c++) begin
            set_px(20, c, 1'b1); tick();
            n_cmp++; if (pix_data !== exp_pix || pix_valid !== exp_valid) begin
                n_fail++; $display("FAIL defer_tail: got %h/%b expected %h/%b", pix_data, pix_valid, exp_pix, exp_valid); end
        end
        // Request withdrawn before it could issue: no write, no ack.
        we0 = we_cnt; ack0 = ack_cnt;
        wr_addr = 16'h0101; wr_data = 8'hEE; wr_req = 1'b1;
        for (int c = 0; c < 4; c++) begin set_px(30, c, 1'b1); tick(); end
        wr_req = 1'b0;
        set_px(30, 300, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (we_cnt !== we0 || ack_cnt !== ack0) begin
            n_fail++; $display("FAIL withdraw: got %0d writes %0d acks expected 0/0", we_cnt - we0, ack_cnt - ack0); end
    endtask

    task automatic test_held_req();
        int we0, ack0, budget;
        we0 = we_cnt; ack0 = ack_cnt;
        set_px(5, 400, 1'b1);
        wr_addr = 16'h0203; wr_data = 8'h77; wr_req = 1'b1;
        budget = 0;
        while (ack_cnt == ack0 && budget < 20) begin tick(); budget++; end
        n_cmp++; if (ack_cnt == ack0) begin n_fail++; $display("FAIL held_first_ack: got none expected ack within 20 cycles"); end
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (we_cnt - we0 !== 1 || ack_cnt - ack0 !== 1) begin
            n_fail++; $display("FAIL held_single: got %0d writes %0d acks expected 1/1", we_cnt - we0, ack_cnt - ack0); end
        wr_req = 1'b0; tick();
        wr_addr = 16'h0204; wr_data = 8'h88; wr_req = 1'b1;
        budget = 0;
        while (ack_cnt - ack0 < 2 && budget < 20) begin tick(); budget++; end
        wr_req = 1'b0;
        tick();
        n_cmp++; if (we_cnt - we0 !== 2 || ack_cnt - ack0 !== 2) begin
            n_fail++; $display("FAIL held_second: got %0d writes %0d acks expected 2/2", we_cnt - we0, ack_cnt - ack0); end
    endtask

    task automatic test_random_traffic();
        int we0, ack0, age, max_age, sel;
        we0 = we_cnt; ack0 = ack_cnt; age = 0; max_age = 0;
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel == 0) begin
                org_x = 10'($urandom_range(0, 700)); org_y = 10'($urandom_range(0, 400));
                set_px(480, 0, 1'b0);
            end else if (sel < 20) begin
                set_px($urandom_range(0, 524), 700, 1'b0);
            end else begin
                set_px(moy + $urandom_range(0, 280) - 12, mox + $urandom_range(0, 280) - 12, 1'b1);
            end
            tick();
            n_cmp++; if (pix_data !== exp_pix || pix_valid !== exp_valid) begin
                n_fail++; $display("FAIL rand_pix: got %h/%b expected %h/%b", pix_data, pix_valid, exp_pix, exp_valid); end
            if (wr_ack === 1'b1) begin
                wr_req = 1'b0; age = 0;
            end else if (!wr_req && ($urandom % 4) == 0) begin
                wr_addr = 16'($urandom); wr_data = 8'($urandom); wr_req = 1'b1; age = 0;
            end else if (wr_req) begin
                age++;
                if (age > max_age) max_age = age;
            end
        end
        wr_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL rand_we_in_window: got %0d expected 0", viol); end
        n_cmp++; if (we_cnt - we0 !== ack_cnt - ack0 || ack_cnt == ack0) begin
            n_fail++; $display("FAIL rand_we_vs_ack: got %0d writes %0d acks expected equal and nonzero",
                               we_cnt - we0, ack_cnt - ack0); end
        n_cmp++; if (max_age > 300) begin n_fail++; $display("FAIL rand_starvation: got wait %0d expected <= 300", max_age); end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            ram[a] = 8'(a) ^ 8'(a >> 8);
            img[a] = 8'(a) ^ 8'(a >> 8);
        end
        model_reset();
        test_reset();
        test_default_origin();
        test_origin_move();
        test_write_outside();
        test_deferred();
        test_held_req();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
